// File: rtl/load_block.sv
// Write-back source selector: registers register-file write data and enable from opcode decode.
// Define LOAD_BLOCK_SIGN_EXT_EN to sign-extend the load-immediate value instead of zero-extending.
module load_block #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IMM_W    = 20,
  parameter logic [6:0]  OP_LOADI = 7'b1111111,
  parameter logic [6:0]  OP_ALU   = 7'b0110011,
  parameter logic [6:0]  OP_NOP   = 7'b0000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        OPCODE,
  input  logic [IMM_W-1:0]  INP,
  input  logic [DATA_W-1:0] ALU_OUT,
  output logic              wr_en_RF,
  output logic [DATA_W-1:0] Data_In_RF,
  output logic              illegal_op
);

  logic              wr_en_d, wr_en_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              illegal_d, illegal_q;
  logic [DATA_W-1:0] imm_ext;

  always_comb begin
    imm_ext = '0;
    imm_ext[IMM_W-1:0] = INP;
`ifdef LOAD_BLOCK_SIGN_EXT_EN
    for (int unsigned i = IMM_W; i < DATA_W; i++) begin
      imm_ext[i] = INP[IMM_W-1];
    end
`endif
  end

  // Unknown or X/Z opcodes fall to the default arm: no write, flag illegal.
  always_comb begin
    wr_en_d   = 1'b0;
    data_d    = data_q;
    illegal_d = 1'b0;
    case (OPCODE)
      OP_LOADI: begin
        wr_en_d = 1'b1;
        data_d  = imm_ext;
      end
      OP_ALU: begin
        wr_en_d = 1'b1;
        data_d  = ALU_OUT;
      end
      OP_NOP: begin
        data_d = data_q;
      end
      default: begin
        data_d    = ALU_OUT;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  assign wr_en_RF   = wr_en_q;
  assign Data_In_RF = data_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_load_block.sv
// Directed self-checking bench for load_block; expected values are hand-computed constants.
module tb_load_block;

  logic        clk;
  logic        rst;
  logic [6:0]  OPCODE;
  logic [19:0] INP;
  logic [31:0] ALU_OUT;
  logic        wr_en_RF;
  logic [31:0] Data_In_RF;
  logic        illegal_op;

  int errors = 0;
  int checks = 0;

`ifdef LOAD_BLOCK_SIGN_EXT_EN
  localparam logic [31:0] ExpAaaaa = 32'hFFFAAAAA;
  localparam logic [31:0] ExpFffff = 32'hFFFFFFFF;
`else
  localparam logic [31:0] ExpAaaaa = 32'h000AAAAA;
  localparam logic [31:0] ExpFffff = 32'h000FFFFF;
`endif

  load_block dut (
    .clk       (clk),
    .rst       (rst),
    .OPCODE    (OPCODE),
    .INP       (INP),
    .ALU_OUT   (ALU_OUT),
    .wr_en_RF  (wr_en_RF),
    .Data_In_RF(Data_In_RF),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] data, input logic wr,
                           input logic ill);
    check({tag, ".data"}, Data_In_RF, data);
    check({tag, ".wr_en"}, {31'd0, wr_en_RF}, {31'd0, wr});
    check({tag, ".illegal"}, {31'd0, illegal_op}, {31'd0, ill});
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [6:0] op, input logic [19:0] imm, input logic [31:0] alu);
    @(negedge clk);
    OPCODE  = op;
    INP     = imm;
    ALU_OUT = alu;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    OPCODE  = 7'b0000000;
    INP     = 20'h0;
    ALU_OUT = 32'h0;
    #2;
    check_all("reset_async", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_over_edge", 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("release_pre_edge", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("first_edge_nop", 32'h0, 1'b0, 1'b0);

    step(7'b1111111, 20'hAAAAA, 32'h0);
    check_all("loadi_aaaaa", ExpAaaaa, 1'b1, 1'b0);

    step(7'b0000000, 20'h55555, 32'h55555555);
    check_all("nop_hold", ExpAaaaa, 1'b0, 1'b0);

    step(7'b0110011, 20'h0, 32'hDEADBEEF);
    check_all("alu_write", 32'hDEADBEEF, 1'b1, 1'b0);

    step(7'b1111111, 20'hFFFFF, 32'h0);
    check_all("loadi_b2b_max", ExpFffff, 1'b1, 1'b0);

    step(7'b1010101, 20'h0, 32'hDEADBEEF);
    check_all("illegal_op", 32'hDEADBEEF, 1'b0, 1'b1);

    step(7'b0000000, 20'h0, 32'h0);
    check_all("nop_after_illegal", 32'hDEADBEEF, 1'b0, 1'b0);

    step(7'b0110011, 20'h0, 32'h13579BDF);
    check_all("alu_write2", 32'h13579BDF, 1'b1, 1'b0);

    // Reset pulse between edges clears outputs immediately.
    @(negedge clk);
    OPCODE = 7'b1111111;
    INP    = 20'h12345;
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_reset_clear", 32'h0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("after_mid_reset", 32'h00012345, 1'b1, 1'b0);

    // Reset held across an edge discards the pending ALU write.
    @(negedge clk);
    OPCODE  = 7'b0110011;
    ALU_OUT = 32'hCAFEF00D;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_discard", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_discard_alu", 32'hCAFEF00D, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
